// File: rtl/pipeline_hazard_sequencer_if.sv
// rtl/pipeline_hazard_sequencer_if.sv - ID-stage/memory inputs and per-stage pipeline controls
interface pipeline_hazard_sequencer_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) ();
    logic             id_valid;
    logic [4:0]       id_opcode;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             branch_taken_ex;
    logic             mem_ready;
    logic             stall_cnt_clr;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_write;
    logic             memwb_bubble;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_rd, branch_taken_ex, mem_ready, stall_cnt_clr,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble,
               mem_error, stall_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_rd, branch_taken_ex, mem_ready, stall_cnt_clr,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble,
               mem_error, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// rtl/pipeline_hazard_sequencer.sv - load-use stall, taken-branch flush and memory-freeze sequencer
module pipeline_hazard_sequencer #(
    parameter int REG_W       = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pipeline_hazard_sequencer_if.slave   hz
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state;
    logic [WC_W-1:0]  wait_cnt;
    logic             mem_error_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             ex_valid, ex_load, ex_memop;
    logic [REG_W-1:0] ex_dest;
    logic             mem_valid, mem_memop;

    logic             d_use_rs, d_use_rt, d_load, d_memop;
    logic [REG_W-1:0] d_dest;

    always_comb begin
        d_use_rs = 1'b0;
        d_use_rt = 1'b0;
        d_load   = 1'b0;
        d_memop  = 1'b0;
        d_dest   = '0;
        case (hz.id_opcode)
            5'b00001, 5'b00101: begin d_use_rs = 1'b1; d_use_rt = 1'b1; d_dest = hz.id_rd; end
            5'b01011, 5'b01100: begin d_use_rs = 1'b1; d_use_rt = 1'b1; end
            5'b10011:           begin d_use_rs = 1'b1; d_dest = hz.id_rt; end
            5'b01101:           begin d_use_rs = 1'b1; d_dest = hz.id_rt; d_load = 1'b1; d_memop = 1'b1; end
            5'b01111:           begin d_use_rs = 1'b1; d_use_rt = 1'b1; d_memop = 1'b1; end
            5'b10010:           begin d_use_rt = 1'b1; d_dest = hz.id_rd; end
            5'b00011:           begin d_dest = hz.id_rt; end
            default:            ;
        endcase
    end

    logic mem_pending, timed_out, freeze, drop, loaduse, stall_event;

    assign mem_pending = mem_valid & mem_memop & ~hz.mem_ready;
    assign timed_out   = (state == MEM_WAIT) && (wait_cnt >= WC_W'(MEM_TIMEOUT));
    assign freeze      = mem_pending & ~timed_out;
    // A timed-out access is abandoned: the pipeline advances and the MEM op never writes back.
    assign drop        = mem_pending & timed_out;
    assign loaduse     = hz.id_valid & ex_valid & ex_load & (ex_dest != '0) &
                         ((d_use_rs & (hz.id_rs == ex_dest)) | (d_use_rt & (hz.id_rt == ex_dest)));
    assign stall_event = freeze | (loaduse & ~hz.branch_taken_ex);

    logic pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b;

    always_comb begin
        pc_w = 1'b0; ifid_w = 1'b0; ifid_f = 1'b0; idex_w = 1'b0;
        idex_b = 1'b0; exmem_w = 1'b0; memwb_b = 1'b0;
        if (!rst_n) begin
            memwb_b = 1'b0;
        end else if (freeze) begin
            memwb_b = 1'b1;
        end else if (hz.branch_taken_ex) begin
            pc_w = 1'b1; ifid_w = 1'b1; ifid_f = 1'b1; idex_w = 1'b1; idex_b = 1'b1; exmem_w = 1'b1;
            memwb_b = drop;
        end else if (loaduse) begin
            idex_w = 1'b1; idex_b = 1'b1; exmem_w = 1'b1;
            memwb_b = drop;
        end else begin
            pc_w = 1'b1; ifid_w = 1'b1; idex_w = 1'b1; exmem_w = 1'b1;
            memwb_b = drop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_load   <= 1'b0;
            ex_memop  <= 1'b0;
            ex_dest   <= '0;
            mem_valid <= 1'b0;
            mem_memop <= 1'b0;
        end else begin
            if (idex_w) begin
                ex_valid <= hz.id_valid & ~idex_b;
                ex_load  <= d_load;
                ex_memop <= d_memop;
                ex_dest  <= d_dest;
            end
            if (exmem_w) begin
                mem_valid <= ex_valid;
                mem_memop <= ex_memop;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_error_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (freeze) begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                        if (drop) mem_error_q <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
            if (hz.stall_cnt_clr) begin
                stall_cnt_q <= '0;
            end else if (stall_event && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.pc_write     = pc_w;
    assign hz.ifid_write   = ifid_w;
    assign hz.ifid_flush   = ifid_f;
    assign hz.idex_write   = idex_w;
    assign hz.idex_bubble  = idex_b;
    assign hz.exmem_write  = exmem_w;
    assign hz.memwb_bubble = memwb_b;
    assign hz.mem_error    = mem_error_q;
    assign hz.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb/tb_pipeline_hazard_sequencer.sv - scoreboard bench for pipeline_hazard_sequencer
module tb_pipeline_hazard_sequencer;
    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_ADDI = 5'b10011;
    localparam logic [4:0] OP_LW   = 5'b01101;
    localparam logic [4:0] OP_SW   = 5'b01111;
    localparam logic [4:0] OP_MOV  = 5'b10010;
    localparam logic [4:0] OP_BEQ  = 5'b01100;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble}
    localparam logic [6:0] NORM = 7'b1101010;
    localparam logic [6:0] FRZ  = 7'b0000001;
    localparam logic [6:0] BR   = 7'b1111110;
    localparam logic [6:0] LU   = 7'b0001110;
    localparam logic [6:0] TO   = 7'b1101011;

    typedef struct {
        logic [6:0]  ctl;
        logic        err;
        logic [15:0] sc;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    exp_t e;
    int   n_vec;
    int   n_bad;
    int   cyc;
    logic [15:0] sc_exp;
    logic        err_exp;

    pipeline_hazard_sequencer_if #(.REG_W(4), .CNT_W(16)) bus ();

    pipeline_hazard_sequencer #(.REG_W(4), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            expect_eq($sformatf("c%0d ctl", e.cyc),
                      {25'd0, bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_write,
                       bus.idex_bubble, bus.exmem_write, bus.memwb_bubble}, {25'd0, e.ctl});
            expect_eq($sformatf("c%0d mem_error", e.cyc), {31'd0, bus.mem_error}, {31'd0, e.err});
            expect_eq($sformatf("c%0d stall_cnt", e.cyc), {16'd0, bus.stall_cnt}, {16'd0, e.sc});
        end
    end

    task automatic step(input logic rst, input logic v, input logic [4:0] op,
                        input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                        input logic br, input logic mr, input logic clr, input logic [6:0] ctl);
        exp_t x;
        rst_n               = rst;
        bus.id_valid        = v;
        bus.id_opcode       = op;
        bus.id_rs           = rs;
        bus.id_rt           = rt;
        bus.id_rd           = rd;
        bus.branch_taken_ex = br;
        bus.mem_ready       = mr;
        bus.stall_cnt_clr   = clr;
        if (!rst) begin
            sc_exp  = 16'd0;
            err_exp = 1'b0;
        end
        x.ctl = rst ? ctl : 7'd0;
        x.err = err_exp;
        x.sc  = sc_exp;
        x.cyc = cyc;
        sb.push_back(x);
        @(posedge clk);
        if (rst) begin
            if (clr) sc_exp = 16'd0;
            else if (!ctl[6] && sc_exp != 16'hFFFF) sc_exp = sc_exp + 16'd1;
            if (ctl == TO) err_exp = 1'b1;
        end
        cyc++;
        #1;
    endtask

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0;
        sc_exp = 16'd0; err_exp = 1'b0;
        rst_n = 1'b0;
        bus.id_valid = 1'b0; bus.id_opcode = OP_NOP; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
        bus.branch_taken_ex = 1'b0; bus.mem_ready = 1'b1; bus.stall_cnt_clr = 1'b0;
        @(posedge clk); #1;

        step(0, 0, OP_NOP, 0, 0, 0, 0, 1, 0, NORM);
        step(0, 1, OP_ADD, 1, 2, 3, 1, 0, 0, NORM);

        // load-use on rs, then the held consumer proceeds
        step(1, 1, OP_LW,   1, 2, 0, 0, 1, 0, NORM);
        step(1, 1, OP_ADD,  2, 5, 6, 0, 1, 0, LU);
        step(1, 1, OP_ADD,  2, 5, 6, 0, 1, 0, NORM);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 1, 0, NORM);
        // load to r0 and non-load producer never stall
        step(1, 1, OP_LW,   1, 0, 0, 0, 1, 0, NORM);
        step(1, 1, OP_ADD,  0, 0, 5, 0, 1, 0, NORM);
        step(1, 1, OP_ADDI, 1, 3, 0, 0, 1, 0, NORM);
        step(1, 1, OP_ADD,  3, 1, 4, 0, 1, 0, NORM);
        // load-use through rt; MOV ignores rs
        step(1, 1, OP_LW,   1, 7, 0, 0, 1, 0, NORM);
        step(1, 1, OP_SW,   4, 7, 0, 0, 1, 0, LU);
        step(1, 1, OP_SW,   4, 7, 0, 0, 1, 0, NORM);
        step(1, 1, OP_LW,   1, 8, 0, 0, 1, 0, NORM);
        step(1, 1, OP_MOV,  8, 9, 1, 0, 1, 0, NORM);
        // taken branch overrides load-use
        step(1, 1, OP_LW,   1, 5, 0, 0, 1, 0, NORM);
        step(1, 1, OP_ADD,  5, 6, 1, 1, 1, 0, BR);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 1, 0, NORM);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 1, 0, NORM);
        // SW waits 3 cycles with a taken BEQ held in EX; flush lands on release
        step(1, 1, OP_SW,   1, 2, 0, 0, 1, 0, NORM);
        step(1, 1, OP_BEQ,  1, 1, 0, 0, 1, 0, NORM);
        step(1, 0, OP_NOP,  0, 0, 0, 1, 0, 0, FRZ);
        step(1, 0, OP_NOP,  0, 0, 0, 1, 0, 0, FRZ);
        step(1, 0, OP_NOP,  0, 0, 0, 1, 0, 0, FRZ);
        step(1, 0, OP_NOP,  0, 0, 0, 1, 1, 0, BR);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 1, 0, NORM);
        // memory never answers: forced release after MEM_TIMEOUT frozen cycles
        step(1, 1, OP_SW,   1, 2, 0, 0, 1, 0, NORM);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 1, 0, NORM);
        for (int i = 0; i < 15; i++) step(1, 0, OP_NOP, 0, 0, 0, 0, 0, 0, FRZ);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 0, 0, TO);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 0, 0, NORM);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 1, 0, NORM);
        // clear, including clear during a stall cycle
        step(1, 0, OP_NOP,  0, 0, 0, 0, 1, 1, NORM);
        step(1, 1, OP_LW,   1, 2, 0, 0, 1, 0, NORM);
        step(1, 1, OP_ADD,  2, 3, 4, 0, 1, 1, LU);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 1, 0, NORM);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 1, 0, NORM);
        // reset asserted while waiting on memory
        step(1, 1, OP_SW,   1, 2, 0, 0, 1, 0, NORM);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 1, 0, NORM);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 0, 0, FRZ);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 0, 0, FRZ);
        step(0, 0, OP_NOP,  0, 0, 0, 0, 0, 0, NORM);
        step(0, 0, OP_NOP,  0, 0, 0, 0, 0, 0, NORM);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 0, 0, NORM);
        step(1, 0, OP_NOP,  0, 0, 0, 0, 1, 0, NORM);

        @(negedge clk);
        expect_eq("sb_drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
